// File: rtl/fetch_unit.sv
// fetch_unit: rv32i fetch stage, one outstanding imem read, skid buffer, redirect discard.
// Define FETCH_ALIGN_CHK_EN to trap misaligned redirect targets via exc_misaligned.
module fetch_unit #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        change_pc,
   input  logic [31:0] next_pc,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
`ifdef FETCH_ALIGN_CHK_EN
   output logic        exc_misaligned,
`endif
   output logic        inst_valid
);
   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;
   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t      state, state_n;
   logic [31:0] pc, pc_n, req_addr, req_addr_n, buf_inst, buf_inst_n, buf_pc, buf_pc_n;
   logic [31:0] inst_n, inst_pc_n, tgt;
   logic        inst_valid_n, exc_q, exc_n, mis;

`ifdef FETCH_ALIGN_CHK_EN
   assign mis = change_pc && (next_pc[1:0] != 2'b00);
   assign tgt = next_pc;
   assign exc_misaligned = exc_q;
`else
   assign mis = 1'b0;
   assign tgt = next_pc & ~32'h3;
`endif

   assign imem_req  = (state == FETCH) || (state == DISCARD);
   assign imem_addr = req_addr;

   always_comb begin
      state_n      = state;
      pc_n         = pc;
      req_addr_n   = req_addr;
      buf_inst_n   = buf_inst;
      buf_pc_n     = buf_pc;
      inst_n       = inst;
      inst_pc_n    = inst_pc;
      inst_valid_n = stall & inst_valid;
      exc_n        = exc_q;
      if (change_pc) begin
         // an unacked request cannot be withdrawn, so its ack is swallowed in DISCARD
         pc_n         = tgt;
         inst_valid_n = 1'b0;
         exc_n        = mis;
         if (imem_req && !imem_ack) state_n = DISCARD;
         else if (mis) state_n = HOLD;
         else begin
            state_n    = FETCH;
            req_addr_n = tgt;
         end
         if (mis) begin
            inst_n       = NOP;
            inst_pc_n    = next_pc;
            inst_valid_n = 1'b1;
         end
      end else begin
         case (state)
            IDLE: begin
               req_addr_n = pc;
               state_n    = FETCH;
            end
            FETCH: if (imem_ack) begin
               pc_n = req_addr + 32'd4;
               if (stall) begin
                  buf_inst_n = imem_rdata;
                  buf_pc_n   = req_addr;
                  state_n    = HOLD;
               end else begin
                  inst_n       = imem_rdata;
                  inst_pc_n    = req_addr;
                  inst_valid_n = 1'b1;
                  req_addr_n   = req_addr + 32'd4;
               end
            end
            HOLD: if (!stall && !exc_q) begin
               inst_n       = buf_inst;
               inst_pc_n    = buf_pc;
               inst_valid_n = 1'b1;
               req_addr_n   = pc;
               state_n      = FETCH;
            end
            DISCARD: if (imem_ack) begin
               req_addr_n = pc;
               state_n    = exc_q ? HOLD : FETCH;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= PC_RESET;
         req_addr   <= PC_RESET;
         buf_inst   <= NOP;
         buf_pc     <= 32'h0;
         inst       <= NOP;
         inst_pc    <= 32'h0;
         inst_valid <= 1'b0;
         exc_q      <= 1'b0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         req_addr   <= req_addr_n;
         buf_inst   <= buf_inst_n;
         buf_pc     <= buf_pc_n;
         inst       <= inst_n;
         inst_pc    <= inst_pc_n;
         inst_valid <= inst_valid_n;
         exc_q      <= exc_n;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit; memory returns addr ^ 32'hDEAD_0000.
module tb_fetch_unit;
   logic        clk = 1'b0, rst = 1'b1, change_pc = 1'b0, stall = 1'b0, ack_en = 1'b1;
   logic [31:0] next_pc = 32'h0;
   logic        imem_req, imem_ack, inst_valid;
   logic [31:0] imem_addr, imem_rdata, inst, inst_pc;
   int          tests = 0, fails = 0;
`ifdef FETCH_ALIGN_CHK_EN
   logic        exc_misaligned;
`endif

   fetch_unit #(.PC_RESET(32'h100)) dut (
      .clk(clk), .rst(rst), .change_pc(change_pc), .next_pc(next_pc), .stall(stall),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst(inst), .inst_pc(inst_pc),
`ifdef FETCH_ALIGN_CHK_EN
      .exc_misaligned(exc_misaligned),
`endif
      .inst_valid(inst_valid)
   );

   assign imem_ack   = imem_req & ack_en;
   assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick();
      tick();
      check("rst_req", imem_req, 0);
      check("rst_addr", imem_addr, 32'h100);
      check("rst_inst", inst, 32'h13);
      check("rst_pc", inst_pc, 0);
      check("rst_valid", inst_valid, 0);
`ifdef FETCH_ALIGN_CHK_EN
      check("rst_exc", exc_misaligned, 0);
`endif
      rst = 1'b0;
      tick();
      check("first_req", imem_req, 1);
      check("first_addr", imem_addr, 32'h100);
      check("first_valid", inst_valid, 0);
      tick();
      check("s1_valid", inst_valid, 1);
      check("s1_inst", inst, 32'hDEAD_0100);
      check("s1_pc", inst_pc, 32'h100);
      check("s1_addr", imem_addr, 32'h104);
      tick();
      check("s2_pc", inst_pc, 32'h104);
      check("s2_addr", imem_addr, 32'h108);
      stall = 1'b1;
      tick();
      check("hold_req", imem_req, 0);
      check("hold_pc", inst_pc, 32'h104);
      check("hold_valid", inst_valid, 1);
      tick();
      tick();
      check("hold3_req", imem_req, 0);
      check("hold3_inst", inst, 32'hDEAD_0104);
      stall = 1'b0;
      tick();
      check("unst_inst", inst, 32'hDEAD_0108);
      check("unst_pc", inst_pc, 32'h108);
      check("unst_valid", inst_valid, 1);
      check("unst_addr", imem_addr, 32'h10C);
      check("unst_req", imem_req, 1);
      ack_en = 1'b0;
      tick();
      check("wait_valid", inst_valid, 0);
      change_pc = 1'b1;
      next_pc = 32'h200;
      tick();
      change_pc = 1'b0;
      check("disc_addr", imem_addr, 32'h10C);
      check("disc_req", imem_req, 1);
      ack_en = 1'b1;
      tick();
      check("redir_addr", imem_addr, 32'h200);
      check("redir_valid", inst_valid, 0);
      check("redir_pc", inst_pc, 32'h108);
      tick();
      check("r200_inst", inst, 32'hDEAD_0200);
      check("r200_pc", inst_pc, 32'h200);
      check("r200_valid", inst_valid, 1);
      change_pc = 1'b1;
      next_pc = 32'h280;
      tick();
      change_pc = 1'b0;
      check("cack_addr", imem_addr, 32'h280);
      check("cack_valid", inst_valid, 0);
      check("cack_pc", inst_pc, 32'h200);
      ack_en = 1'b0;
      change_pc = 1'b1;
      next_pc = 32'h300;
      tick();
      next_pc = 32'h400;
      tick();
      check("dd_addr", imem_addr, 32'h280);
      change_pc = 1'b0;
      ack_en = 1'b1;
      tick();
      check("dd_redir", imem_addr, 32'h400);
      check("dd_valid", inst_valid, 0);
      tick();
      check("dd_pc", inst_pc, 32'h400);
      check("dd_inst", inst, 32'hDEAD_0400);
      change_pc = 1'b1;
      next_pc = 32'hFFFF_FFFC;
      tick();
      change_pc = 1'b0;
      check("wrap_top", imem_addr, 32'hFFFF_FFFC);
      tick();
      check("wrap_addr", imem_addr, 32'h0);
      check("wrap_pc", inst_pc, 32'hFFFF_FFFC);
      check("wrap_inst", inst, 32'h2152_FFFC);
`ifdef FETCH_ALIGN_CHK_EN
      change_pc = 1'b1;
      next_pc = 32'h202;
      tick();
      change_pc = 1'b0;
      check("mis_req", imem_req, 0);
      check("mis_exc", exc_misaligned, 1);
      check("mis_inst", inst, 32'h13);
      check("mis_pc", inst_pc, 32'h202);
      check("mis_valid", inst_valid, 1);
      tick();
      check("mis_idle", imem_req, 0);
      check("mis_exc2", exc_misaligned, 1);
      change_pc = 1'b1;
      next_pc = 32'h600;
      tick();
      change_pc = 1'b0;
      check("mis_clr", exc_misaligned, 0);
      check("mis_addr", imem_addr, 32'h600);
      check("mis_req2", imem_req, 1);
`else
      change_pc = 1'b1;
      next_pc = 32'h503;
      tick();
      change_pc = 1'b0;
      check("align_addr", imem_addr, 32'h500);
      tick();
      check("align_pc", inst_pc, 32'h500);
`endif
      ack_en = 1'b0;
      tick();
      check("pre_rst_req", imem_req, 1);
      rst = 1'b1;
      tick();
      check("mrst_req", imem_req, 0);
      check("mrst_addr", imem_addr, 32'h100);
      check("mrst_valid", inst_valid, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the rv32i pipeline and the consumer of the writeback stage's PC-control outputs. Holds the architectural PC, issues one-outstanding request/acknowledge reads to instruction memory, and presents each fetched instruction with its PC to decode. Redirects on `change_pc`/`next_pc`, discarding in-flight and buffered fetches. Holds its output while downstream asserts `stall`.

## Interface
- `PC_RESET`, 32'h0000_0000, PC fetched first after reset
- `clk` input 1: single clock, all state updates on rising edge
- `rst` input 1: synchronous, active-high reset
- `change_pc` input 1: redirect request from writeback
- `next_pc` input 32: redirect target, valid when `change_pc`=1
- `stall` input 1: downstream cannot accept; hold outputs
- `imem_req` output 1: memory read request
- `imem_addr` output 32: request address, stable while `imem_req`=1 and not acked
- `imem_ack` input 1: read data valid this cycle
- `imem_rdata` input 32: instruction word, sampled when `imem_ack`=1
- `inst` output 32: fetched instruction to decode
- `inst_pc` output 32: PC of `inst`
- `inst_valid` output 1: `inst`/`inst_pc` valid (decode clock enable)
- `exc_misaligned` output 1: only with `FETCH_ALIGN_CHK_EN`

## Operation
- Registers:
  - `pc`: next address to request.
  - `req_addr`: drives `imem_addr`.
  - `buf_inst`, `buf_pc`: skid buffer.
  - Output registers.
  - 2-bit `state`.
- States:
  - `IDLE`: entered from reset only. Next cycle: `req_addr`<=`pc`, go `FETCH`.
  - `FETCH`: `imem_req`=1.
    - On `imem_ack` with `stall`=0: `inst`<=`imem_rdata`, `inst_pc`<=`req_addr`, `inst_valid`<=1, `pc`/`req_addr`<=`req_addr`+4. Stay in `FETCH` (back-to-back, 1 instruction/cycle at 0-wait memory).
    - On `imem_ack` with `stall`=1: capture into `buf_*`, `pc`<=`req_addr`+4, go `HOLD`.
  - `HOLD`: `imem_req`=0, outputs frozen. When `stall`=0: load `buf_*` into outputs, `inst_valid`<=1, `req_addr`<=`pc`, go `FETCH`.
  - `DISCARD`: `imem_req`=1 at the old `req_addr`. Wait for `imem_ack`, drop the data, then `req_addr`<=`pc` and go `FETCH`.
- `stall`=1 freezes `inst`, `inst_pc` and `inst_valid`.
- `stall`=0 with no new instruction this cycle: `inst_valid`<=0.
- `change_pc` has priority over everything except `rst`. `pc`<=`next_pc`, `inst_valid`<=0 regardless of `stall`, then:
  - `FETCH` without ack: go `DISCARD`. The request cannot be withdrawn.
  - `FETCH` with ack same cycle: drop data, `req_addr`<=`next_pc`, stay `FETCH`.
  - `HOLD`: drop buffer, `req_addr`<=`next_pc`, go `FETCH`.
  - `DISCARD`: update `pc` only. A later `change_pc` overrides an earlier one (last wins).
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values:
  - `imem_req`=0
  - `imem_addr`=`PC_RESET`
  - `inst`=32'h0000_0013 (NOP)
  - `inst_pc`=0
  - `inst_valid`=0
  - `exc_misaligned`=0
  - `state`=`IDLE`
- First `imem_req`=1 occurs 1 cycle after `rst` deasserts.
- Latency: `imem_ack` at edge N gives `inst_valid`=1 from edge N+1.
- Redirect: `change_pc` at edge N gives `imem_addr`=`next_pc` at N+1 when no request is outstanding. Otherwise one cycle after the pending ack.
- `imem_addr` changes only on the ack edge, a redirect without a pending request, or an `IDLE`/`HOLD` exit.
- `rst` mid-request: abandon immediately, `imem_req`=0 next cycle. The memory must tolerate a withdrawn request at reset.

## Configuration
- `FETCH_ALIGN_CHK_EN` defined:
  - A `next_pc` with [1:0]!=0 is not requested.
  - Next cycle: `inst_valid`=1, `inst`=NOP, `inst_pc`=target, `exc_misaligned`=1.
  - The unit then idles in `HOLD` with `imem_req`=0 until the next `change_pc`.
  - `exc_misaligned` clears on the next `change_pc` or `rst`.
- Undefined:
  - `exc_misaligned` port is absent.
  - `next_pc[1:0]` is forced to 2'b00.

## Test plan
- Reset with `PC_RESET`=32'h100, 0-wait ack -> `imem_addr` 0x100, 0x104, 0x108 on consecutive cycles; `inst_valid`=1 from 2nd cycle after reset release; `inst_pc` tracks one cycle behind.
- Ack with `stall`=1 for 3 cycles -> `imem_req`=0 during `HOLD`; buffered word appears when `stall` drops; no word lost or duplicated.
- `change_pc` with `next_pc`=0x200 while request to 0x10C awaits 2-cycle ack -> 0x10C data dropped; next request 0x200; `inst_valid` stays 0 until the 0x200 data.
- `change_pc` coinciding with ack -> data dropped; `imem_addr`=`next_pc` next cycle.
- `change_pc` twice during `DISCARD` (0x300, then 0x400) -> only 0x400 requested.
- With `FETCH_ALIGN_CHK_EN`, `next_pc`=0x202 -> no request; `exc_misaligned`=1; `inst`=0x00000013; `inst_pc`=0x202.
